riscv_core_muldiv_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined mul/div unit (`riscv_CoreDpathPipeMulDiv`) between two requesters, e.g. two issue ports or a core plus an accelerator. It grants at most one request per cycle, records each grantee in an in-order owner FIFO, and returns each response to the requester that issued it. It sits between the requesters and the unit's request/response handshake ports. It owns credit-based flow control and error detection for unexpected responses.

---
 rtl/riscv_core_muldiv_arbiter.sv | 110 +++++++++++
 tb/tb_riscv_core_muldiv_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_muldiv_arbiter.sv
// rtl/riscv_core_muldiv_arbiter.sv - round-robin sharing of one pipelined mul/div unit between two requesters
module riscv_core_muldiv_arbiter #(
  parameter int INFLIGHT = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2:0]                req0_msg_fn,
  input  logic [31:0]               req0_msg_a,
  input  logic [31:0]               req0_msg_b,
  input  logic                      req0_val,
  output logic                      req0_rdy,
  input  logic [2:0]                req1_msg_fn,
  input  logic [31:0]               req1_msg_a,
  input  logic [31:0]               req1_msg_b,
  input  logic                      req1_val,
  output logic                      req1_rdy,
  output logic [63:0]               resp0_msg_result,
  output logic                      resp0_val,
  input  logic                      resp0_rdy,
  output logic [63:0]               resp1_msg_result,
  output logic                      resp1_val,
  input  logic                      resp1_rdy,
  output logic [2:0]                muldivreq_msg_fn,
  output logic [31:0]               muldivreq_msg_a,
  output logic [31:0]               muldivreq_msg_b,
  output logic                      muldivreq_val,
  input  logic                      muldivreq_rdy,
  input  logic [63:0]               muldivresp_msg_result,
  input  logic                      muldivresp_val,
  output logic                      muldivresp_rdy,
  output logic [$clog2(INFLIGHT):0] inflight_cnt,
  output logic                      err
);
  localparam int PW = $clog2(INFLIGHT);
  localparam int CW = PW + 1;

  logic          prio;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          owner [INFLIGHT];

  logic fifo_empty;
  logic own;
  logic can_issue;
  logic grant0;
  logic grant1;
  logic push;
  logic pop;
  logic sel;

  // The credit check uses the registered count only, so a pop never frees a slot in the same cycle.
  assign fifo_empty = (cnt == '0);
  assign can_issue  = reset_n && muldivreq_rdy && (cnt < CW'(INFLIGHT));
  assign grant0     = can_issue && req0_val && (!req1_val || !prio);
  assign grant1     = can_issue && req1_val && (!req0_val || prio);
  assign push       = grant0 || grant1;
  assign sel        = grant1 || (!grant0 && prio);

  assign req0_rdy         = grant0;
  assign req1_rdy         = grant1;
  assign muldivreq_val    = push;
  assign muldivreq_msg_fn = sel ? req1_msg_fn : req0_msg_fn;
  assign muldivreq_msg_a  = sel ? req1_msg_a  : req0_msg_a;
  assign muldivreq_msg_b  = sel ? req1_msg_b  : req0_msg_b;

  // An empty FIFO still accepts (drains) a response so a stray one cannot wedge the unit.
  assign own              = owner[rd_ptr];
  assign resp0_val        = reset_n && !fifo_empty && !own && muldivresp_val;
  assign resp1_val        = reset_n && !fifo_empty && own && muldivresp_val;
  assign resp0_msg_result = muldivresp_msg_result;
  assign resp1_msg_result = muldivresp_msg_result;
  assign muldivresp_rdy   = reset_n && (fifo_empty || (own ? resp1_rdy : resp0_rdy));
  assign pop              = muldivresp_val && muldivresp_rdy && !fifo_empty;

  assign inflight_cnt = cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      owner[wr_ptr] <= grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        prio   <= !grant1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (muldivresp_val && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_muldiv_arbiter.sv
// tb/tb_riscv_core_muldiv_arbiter.sv - scoreboard bench with a behavioural unit stub for riscv_core_muldiv_arbiter
module tb_riscv_core_muldiv_arbiter;
  localparam int INFLIGHT = 4;
  localparam int LAT      = 4;
  localparam int UCAP     = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  req0_msg_fn, req1_msg_fn;
  logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
  logic        req0_val, req1_val, req0_rdy, req1_rdy;
  logic [63:0] resp0_msg_result, resp1_msg_result;
  logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val, muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val, muldivresp_rdy;
  logic [$clog2(INFLIGHT):0] inflight_cnt;
  logic        err;

  riscv_core_muldiv_arbiter #(.INFLIGHT(INFLIGHT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
    .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
    .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy), .inflight_cnt(inflight_cnt), .err(err)
  );

  typedef struct { logic id; logic [63:0] res; } sb_t;
  typedef struct { logic [63:0] res; int age; } unit_t;

  sb_t   sb[$];
  unit_t u_q[$];
  sb_t   mon_e;

  int checks = 0;
  int errors = 0;
  int cnt_m;
  bit prio_m, err_m;
  bit unit_free, orphan_inj;
  int resp_stall_pct;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // MUL gives the full product; divides give {remainder, quotient}.
  function automatic logic [63:0] ref_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    if (fn == 3'd0) begin
      p = $signed(a) * $signed(b);
      return p;
    end
    if (b == 32'd0) return {a, 32'hffff_ffff};
    if (fn == 3'd1 || fn == 3'd3) begin
      if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'd0, a};
      return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    end
    return {a % b, a / b};
  endfunction

  task automatic drive_unit();
    foreach (u_q[i]) u_q[i].age++;
    muldivresp_val        = orphan_inj || (u_q.size() > 0 && u_q[0].age >= LAT);
    muldivresp_msg_result = (u_q.size() > 0) ? u_q[0].res : {$urandom, $urandom};
    muldivreq_rdy         = (u_q.size() < UCAP) && (unit_free || ($urandom_range(0, 3) != 0));
    resp0_rdy             = ($urandom_range(0, 99) >= resp_stall_pct);
    resp1_rdy             = ($urandom_range(0, 99) >= resp_stall_pct);
  endtask

  task automatic tick();
    bit g0, g1, can, pop, sel;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_req0_rdy", req0_rdy, 0);
      chk("rst_req1_rdy", req1_rdy, 0);
      chk("rst_resp0_val", resp0_val, 0);
      chk("rst_resp1_val", resp1_val, 0);
      chk("rst_muldivreq_val", muldivreq_val, 0);
      chk("rst_muldivresp_rdy", muldivresp_rdy, 0);
      cnt_m = 0; prio_m = 0; err_m = 0;
      sb.delete();
      u_q.delete();
    end else begin
      chk("inflight_cnt", inflight_cnt, cnt_m);
      chk("err", err, err_m);
      can = muldivreq_rdy && (cnt_m < INFLIGHT);
      g0  = can && req0_val && (!req1_val || !prio_m);
      g1  = can && req1_val && (!req0_val || prio_m);
      chk("req0_rdy", req0_rdy, g0);
      chk("req1_rdy", req1_rdy, g1);
      chk("muldivreq_val", muldivreq_val, g0 || g1);
      sel = g1 || (!g0 && prio_m);
      chk("muldivreq_msg_fn", muldivreq_msg_fn, sel ? req1_msg_fn : req0_msg_fn);
      chk("muldivreq_msg_a", muldivreq_msg_a, sel ? req1_msg_a : req0_msg_a);
      chk("muldivreq_msg_b", muldivreq_msg_b, sel ? req1_msg_b : req0_msg_b);
      if (g0) sb.push_back('{id: 1'b0, res: ref_op(req0_msg_fn, req0_msg_a, req0_msg_b)});
      if (g1) sb.push_back('{id: 1'b1, res: ref_op(req1_msg_fn, req1_msg_a, req1_msg_b)});
      if (muldivreq_val && muldivreq_rdy)
        u_q.push_back('{res: ref_op(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b), age: 0});
      if (muldivresp_val && cnt_m == 0) begin
        chk("orphan_resp0_val", resp0_val, 0);
        chk("orphan_resp1_val", resp1_val, 0);
        chk("orphan_muldivresp_rdy", muldivresp_rdy, 1);
        err_m = 1;
      end
      pop = muldivresp_val && muldivresp_rdy && (cnt_m != 0);
      if (muldivresp_val && muldivresp_rdy && u_q.size() > 0) void'(u_q.pop_front());
      cnt_m = cnt_m + int'(g0 || g1) - int'(pop);
      if (g0 || g1) prio_m = g0;
    end
    @(posedge clk);
    #1;
    drive_unit();
  endtask

  task automatic drain();
    int n = 0;
    req0_val = 0; req1_val = 0;
    unit_free = 1; resp_stall_pct = 0;
    while ((sb.size() != 0 || u_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) tick();
  endtask

  task automatic random_reqs();
    req0_val    = $urandom_range(0, 1);
    req1_val    = $urandom_range(0, 1);
    req0_msg_fn = $urandom_range(0, 4);
    req1_msg_fn = $urandom_range(0, 4);
    req0_msg_a  = $urandom;
    req1_msg_a  = $urandom;
    req0_msg_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    req1_msg_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
  endtask

  // Response monitor: every delivered response must match the oldest outstanding issue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (sb.size() > 0 && muldivresp_val) begin
          mon_e = sb[0];
          chk("resp0_val_route", resp0_val, mon_e.id == 1'b0);
          chk("resp1_val_route", resp1_val, mon_e.id == 1'b1);
          chk("muldivresp_rdy_route", muldivresp_rdy, mon_e.id ? resp1_rdy : resp0_rdy);
          if (!mon_e.id && resp0_val && resp0_rdy) begin
            chk("resp0_result", resp0_msg_result, mon_e.res);
            void'(sb.pop_front());
          end else if (mon_e.id && resp1_val && resp1_rdy) begin
            chk("resp1_result", resp1_msg_result, mon_e.res);
            void'(sb.pop_front());
          end
        end else if (resp0_val || resp1_val) begin
          chk("resp_unexpected", {resp0_val, resp1_val}, 0);
        end
      end
    end
  end

  initial begin
    reset_n = 0; unit_free = 1; orphan_inj = 0; resp_stall_pct = 0;
    muldivresp_val = 0; muldivresp_msg_result = '0; muldivreq_rdy = 1;
    resp0_rdy = 1; resp1_rdy = 1;
    random_reqs();
    req0_val = 1; req1_val = 1;
    repeat (3) tick();
    reset_n = 1;

    // Both requesters every cycle: grants alternate, results 15 and 63.
    req0_val = 1; req0_msg_fn = 3'd0; req0_msg_a = 32'd3; req0_msg_b = 32'd5;
    req1_val = 1; req1_msg_fn = 3'd0; req1_msg_a = 32'd7; req1_msg_b = 32'd9;
    repeat (12) tick();
    drain();

    // Single requester, DIVU 100/7 back to back.
    req1_val = 1; req1_msg_fn = 3'd2; req1_msg_a = 32'd100; req1_msg_b = 32'd7;
    repeat (3) tick();
    drain();

    // Random traffic with unit stalls and requester backpressure.
    unit_free = 0; resp_stall_pct = 40;
    repeat (400) begin
      random_reqs();
      tick();
    end
    drain();

    // Mid-flight reset with responses held back.
    resp_stall_pct = 100;
    for (int i = 0; i < 50 && cnt_m < 3; i++) begin
      random_reqs();
      req0_val = 1;
      tick();
    end
    chk("midflight_outstanding", inflight_cnt >= 3, 1);
    reset_n = 0;
    tick();
    reset_n = 1;
    resp_stall_pct = 0; unit_free = 1;
    resp0_rdy = 1; resp1_rdy = 1; muldivreq_rdy = 1;
    random_reqs();
    req0_val = 1; req1_val = 1;
    tick();
    drain();

    // Orphan response with an empty owner FIFO.
    orphan_inj = 1;
    muldivresp_val = 1;
    tick();
    orphan_inj = 0;
    repeat (4) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
